guess_checker: RTL and testbench

//  Hangman game-logic stage directly upstream of the host display. Holds the
//  5-letter secret word and a record of letters already guessed. It compares

---
 rtl/guess_checker.sv | 254 +++++++++++++++++++++++++
 tb/tb_guess_checker.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/guess_checker.sv
// Hangman guess checker: holds the secret word and used letters, scores each guess.
// Latency: guess accepted at edge E0, registered result and update strobe after E1.
// Backpressure: guessReady is high only in PLAY; guesses offered at other times are dropped.
//
// Ports:
//   clk, nRst     : clock (rising edge), asynchronous active-low reset
//   setWord, word : one-cycle strobe loading a new 5-letter word (word[39:32] = position 0)
//   guessValid,
//   guess         : offered guess byte, taken when guessValid & guessReady
//   guessReady    : block is in PLAY and will accept a guess
//   letter        : last scored guess letter
//   indexCorrect  : positions hit by the last scored guess (bit4 = position 0)
//   correct       : positions revealed so far (0..5)
//   numMistake    : wrong guesses so far (0..MAX_MISTAKES)
//   mistake       : last scored guess missed
//   update        : one-cycle strobe, display outputs carry a new result
//   gameOver, win : game finished; win when the word was fully revealed

module guess_checker #(
  parameter int unsigned MAX_MISTAKES = 6
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        setWord,
  input  logic [39:0] word,
  input  logic        guessValid,
  input  logic [7:0]  guess,
  output logic        guessReady,
  output logic [7:0]  letter,
  output logic [4:0]  indexCorrect,
  output logic [2:0]  correct,
  output logic [2:0]  numMistake,
  output logic        mistake,
  output logic        update,
  output logic        gameOver,
  output logic        win
);

  generate
    if (MAX_MISTAKES < 1 || MAX_MISTAKES > 7) begin : g_bad_param
      $error("guess_checker: MAX_MISTAKES must be in 1..7");
    end
  endgenerate

  localparam logic [2:0] LP_MAX_MISTAKES = 3'(MAX_MISTAKES);
  localparam logic [7:0] LP_CHAR_A       = 8'h41;
  localparam logic [7:0] LP_CHAR_Z       = 8'h5A;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    CHECK = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Registered state
  state_t      r_state;
  logic [39:0] r_word;
  logic [4:0]  r_revealed;
  logic [25:0] r_used;
  logic [7:0]  r_guess;
  logic        r_guessReady;
  logic [7:0]  r_letter;
  logic [4:0]  r_indexCorrect;
  logic [2:0]  r_correct;
  logic [2:0]  r_numMistake;
  logic        r_mistake;
  logic        r_update;
  logic        r_gameOver;
  logic        r_win;

  // Next-state values
  state_t      w_state;
  logic [39:0] w_word;
  logic [4:0]  w_revealed;
  logic [25:0] w_used;
  logic [7:0]  w_guess;
  logic        w_guessReady;
  logic [7:0]  w_letter;
  logic [4:0]  w_indexCorrect;
  logic [2:0]  w_correct;
  logic [2:0]  w_numMistake;
  logic        w_mistake;
  logic        w_update;
  logic        w_gameOver;
  logic        w_win;

  // Scoring helpers, all derived from the latched guess
  logic [4:0]  w_match;
  logic        w_inRange;
  logic [4:0]  w_usedIdx;
  logic [25:0] w_letterBit;
  logic        w_alreadyUsed;
  logic [4:0]  w_newRevealed;
  logic [2:0]  w_newCorrect;
  logic [2:0]  w_newMistakes;

  function automatic logic [2:0] f_popcount5(input logic [4:0] v);
    f_popcount5 = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]}
                + {2'b00, v[3]} + {2'b00, v[4]};
  endfunction

  // Byte k of the word sits at [8k+7:8k]; position 0 is byte 4, so match
  // bit k lines up directly with indexCorrect bit k.
  always_comb begin
    for (int k = 0; k < 5; k++) begin
      w_match[k] = (r_word[8*k +: 8] == r_guess);
    end
  end

  assign w_inRange     = (r_guess >= LP_CHAR_A) && (r_guess <= LP_CHAR_Z);
  // 'A'..'Z' are 0x41..0x5A, so the low five bits minus one give 0..25.
  assign w_usedIdx     = r_guess[4:0] - 5'd1;
  assign w_letterBit   = 26'd1 << w_usedIdx;
  assign w_alreadyUsed = |(r_used & w_letterBit);
  assign w_newRevealed = r_revealed | w_match;
  assign w_newCorrect  = f_popcount5(w_newRevealed);
  // Saturating increment; in practice the game ends before the limit is passed.
  assign w_newMistakes = (r_numMistake < LP_MAX_MISTAKES) ? (r_numMistake + 3'd1)
                                                          : r_numMistake;

  always_comb begin
    w_state        = r_state;
    w_word         = r_word;
    w_revealed     = r_revealed;
    w_used         = r_used;
    w_guess        = r_guess;
    w_letter       = r_letter;
    w_indexCorrect = r_indexCorrect;
    w_correct      = r_correct;
    w_numMistake   = r_numMistake;
    w_mistake      = r_mistake;
    w_update       = 1'b0;
    w_gameOver     = r_gameOver;
    w_win          = r_win;

    case (r_state)
      IDLE: begin
        w_state = IDLE;
      end

      PLAY: begin
        if (guessValid && r_guessReady) begin
          w_guess = guess;
          w_state = CHECK;
        end
      end

      CHECK: begin
        if (!w_inRange || w_alreadyUsed) begin
          // Non-letters and repeats are discarded without touching the display.
          w_state = PLAY;
        end else begin
          w_used   = r_used | w_letterBit;
          w_update = 1'b1;
          w_letter = r_guess;
          if (w_match != 5'd0) begin
            w_revealed     = w_newRevealed;
            w_indexCorrect = w_match;
            w_mistake      = 1'b0;
            w_correct      = w_newCorrect;
          end else begin
            w_indexCorrect = 5'd0;
            w_mistake      = 1'b1;
            w_numMistake   = w_newMistakes;
          end

          if ((w_match != 5'd0) && (w_newCorrect == 3'd5)) begin
            w_state    = DONE;
            w_gameOver = 1'b1;
            w_win      = 1'b1;
          end else if ((w_match == 5'd0) && (w_newMistakes == LP_MAX_MISTAKES)) begin
            w_state    = DONE;
            w_gameOver = 1'b1;
            w_win      = 1'b0;
          end else begin
            w_state = PLAY;
          end
        end
      end

      DONE: begin
        w_state = DONE;
      end

      default: begin
        w_state = IDLE;
      end
    endcase

    // A new word overrides everything, including an in-flight check.
    if (setWord) begin
      w_word         = word;
      w_revealed     = 5'd0;
      w_used         = 26'd0;
      w_letter       = 8'd0;
      w_indexCorrect = 5'd0;
      w_correct      = 3'd0;
      w_numMistake   = 3'd0;
      w_mistake      = 1'b0;
      w_update       = 1'b0;
      w_gameOver     = 1'b0;
      w_win          = 1'b0;
      w_state        = PLAY;
    end

    w_guessReady = (w_state == PLAY);
  end

  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state        <= IDLE;
      r_word         <= 40'd0;
      r_revealed     <= 5'd0;
      r_used         <= 26'd0;
      r_guess        <= 8'd0;
      r_guessReady   <= 1'b0;
      r_letter       <= 8'd0;
      r_indexCorrect <= 5'd0;
      r_correct      <= 3'd0;
      r_numMistake   <= 3'd0;
      r_mistake      <= 1'b0;
      r_update       <= 1'b0;
      r_gameOver     <= 1'b0;
      r_win          <= 1'b0;
    end else begin
      r_state        <= w_state;
      r_word         <= w_word;
      r_revealed     <= w_revealed;
      r_used         <= w_used;
      r_guess        <= w_guess;
      r_guessReady   <= w_guessReady;
      r_letter       <= w_letter;
      r_indexCorrect <= w_indexCorrect;
      r_correct      <= w_correct;
      r_numMistake   <= w_numMistake;
      r_mistake      <= w_mistake;
      r_update       <= w_update;
      r_gameOver     <= w_gameOver;
      r_win          <= w_win;
    end
  end

  assign guessReady   = r_guessReady;
  assign letter       = r_letter;
  assign indexCorrect = r_indexCorrect;
  assign correct      = r_correct;
  assign numMistake   = r_numMistake;
  assign mistake      = r_mistake;
  assign update       = r_update;
  assign gameOver     = r_gameOver;
  assign win          = r_win;

endmodule

// File: tb/tb_guess_checker.sv
// Testbench for guess_checker: game-level reference model compared every cycle,
// plus directed games with hand-computed expectations.
module tb_guess_checker;

  localparam int MAXM = 6;

  logic        clk        = 1'b0;
  logic        nRst       = 1'b0;
  logic        setWord    = 1'b0;
  logic [39:0] word       = 40'd0;
  logic        guessValid = 1'b0;
  logic [7:0]  guess      = 8'd0;
  logic        guessReady;
  logic [7:0]  letter;
  logic [4:0]  indexCorrect;
  logic [2:0]  correct;
  logic [2:0]  numMistake;
  logic        mistake;
  logic        update;
  logic        gameOver;
  logic        win;

  int checks   = 0;
  int failures = 0;

  guess_checker #(.MAX_MISTAKES(MAXM)) dut (
    .clk(clk), .nRst(nRst), .setWord(setWord), .word(word),
    .guessValid(guessValid), .guess(guess), .guessReady(guessReady),
    .letter(letter), .indexCorrect(indexCorrect), .correct(correct),
    .numMistake(numMistake), .mistake(mistake), .update(update),
    .gameOver(gameOver), .win(win)
  );

  always #5 clk = ~clk;

  // ---------------- game-level reference model ----------------
  logic [7:0] m_word [5];
  bit         m_used [26];
  bit         m_rev  [5];
  bit         m_live;      // a game is running and not finished
  bit         m_pend;      // a guess has been taken and is being scored
  logic [7:0] m_g;
  logic [7:0] e_letter;
  logic [4:0] e_idx;
  int         e_correct;
  int         e_nmis;
  bit         e_mis, e_upd, e_over, e_win;

  always @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      for (int i = 0; i < 5; i++) begin m_word[i] = 8'd0; m_rev[i] = 0; end
      for (int i = 0; i < 26; i++) m_used[i] = 0;
      m_live = 0; m_pend = 0; m_g = 8'd0;
      e_letter = 8'd0; e_idx = 5'd0; e_correct = 0; e_nmis = 0;
      e_mis = 0; e_upd = 0; e_over = 0; e_win = 0;
    end else if (setWord) begin
      for (int i = 0; i < 5; i++) begin m_word[i] = word[39-8*i -: 8]; m_rev[i] = 0; end
      for (int i = 0; i < 26; i++) m_used[i] = 0;
      m_live = 1; m_pend = 0;
      e_letter = 8'd0; e_idx = 5'd0; e_correct = 0; e_nmis = 0;
      e_mis = 0; e_upd = 0; e_over = 0; e_win = 0;
    end else if (m_pend) begin
      int li;
      int hits;
      m_pend = 0;
      e_upd  = 0;
      li = int'(m_g) - 65;
      if (li >= 0 && li < 26) begin
        if (!m_used[li]) begin
          m_used[li] = 1;
          e_upd      = 1;
          e_letter   = m_g;
          hits       = 0;
          e_idx      = 5'd0;
          for (int i = 0; i < 5; i++) begin
            if (m_word[i] == m_g) begin
              hits++;
              m_rev[i]   = 1;
              e_idx[4-i] = 1'b1;
            end
          end
          if (hits > 0) e_mis = 0;
          else begin
            e_mis = 1;
            if (e_nmis < MAXM) e_nmis++;
          end
          e_correct = 0;
          for (int i = 0; i < 5; i++) if (m_rev[i]) e_correct++;
          if (e_correct == 5) begin
            e_over = 1; e_win = 1; m_live = 0;
          end else if (e_nmis == MAXM) begin
            e_over = 1; e_win = 0; m_live = 0;
          end
        end
      end
    end else begin
      e_upd = 0;
      if (m_live && guessValid) begin
        m_pend = 1;
        m_g    = guess;
      end
    end
  end

  // ---------------- checking helpers ----------------
  task automatic cmp_cycle();
    logic [23:0] act, exp;
    act = {guessReady, letter, indexCorrect, correct, numMistake, mistake, update, gameOver, win};
    exp = {(m_live && !m_pend), e_letter, e_idx, 3'(e_correct), 3'(e_nmis), e_mis, e_upd, e_over, e_win};
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL model_cycle t=%0t actual=%h expected=%h (rdy,letter,idx,corr,nmis,mis,upd,over,win)",
               $time, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    cmp_cycle();
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic set_word(input logic [39:0] w);
    setWord = 1'b1;
    word    = w;
    tick();
    setWord = 1'b0;
  endtask

  // Offer a guess for one cycle, then wait for the scoring edge.
  task automatic do_guess(input logic [7:0] g);
    guessValid = 1'b1;
    guess      = g;
    tick();
    guessValid = 1'b0;
    tick();
  endtask

  logic [7:0] seq_apple [4] = '{8'h41, 8'h50, 8'h4C, 8'h45};
  int         cor_apple [4] = '{1, 3, 4, 5};
  logic [7:0] wrongs    [6] = '{8'h5A, 8'h51, 8'h58, 8'h57, 8'h56, 8'h55};

  initial begin
    // 1: reset
    repeat (3) tick();
    chk("rst_ready", guessReady, 0);
    chk("rst_outs", {letter, indexCorrect, correct, numMistake, mistake, update, gameOver, win}, 0);
    nRst = 1'b1;
    tick(); tick();
    chk("idle_ready", guessReady, 0);
    guessValid = 1'b1; guess = 8'h41;
    tick();
    guessValid = 1'b0;
    tick();
    chk("idle_guess_ignored", update, 0);

    set_word("APPLE");
    chk("play_ready", guessReady, 1);
    chk("play_counters", {correct, numMistake, gameOver}, 0);

    // 2: guess 'P'
    do_guess(8'h50);
    chk("p_update", update, 1);
    chk("p_index", indexCorrect, 5'b01100);
    chk("p_correct", correct, 2);
    chk("p_mistake", mistake, 0);
    chk("p_letter", letter, 8'h50);
    tick();
    chk("p_update_pulse", update, 0);

    // 5: repeat, lower case, just outside A..Z
    do_guess(8'h50);
    chk("rep_update", update, 0);
    chk("rep_correct", correct, 2);
    chk("rep_ready", guessReady, 1);
    do_guess(8'h61);
    chk("lower_update", update, 0);
    chk("lower_state", {numMistake, mistake, letter}, {3'd0, 1'b0, 8'h50});
    do_guess(8'h40);
    do_guess(8'h5B);
    chk("range_nmis", numMistake, 0);

    do_guess(8'h41); chk("g1_a_correct", correct, 3);
    do_guess(8'h4C); chk("g1_l_correct", correct, 4);
    do_guess(8'h45);
    chk("g1_e_correct", correct, 5);
    chk("g1_win", {win, gameOver, guessReady}, 3'b110);
    do_guess(8'h58);
    chk("g1_after_over", {update, letter, numMistake}, {1'b0, 8'h45, 3'd0});

    // 4: APPLE in order A,P,L,E
    set_word("APPLE");
    for (int i = 0; i < 4; i++) begin
      do_guess(seq_apple[i]);
      chk("g2_correct", correct, 32'(cor_apple[i]));
    end
    chk("g2_win", {win, gameOver}, 2'b11);

    // 3: six wrong guesses with a hit in the middle
    set_word("APPLE");
    for (int i = 0; i < 6; i++) begin
      do_guess(wrongs[i]);
      chk("g3_nmis", numMistake, 32'(i + 1));
      chk("g3_mistake", {mistake, update, indexCorrect}, {1'b1, 1'b1, 5'd0});
      if (i == 2) begin
        do_guess(8'h41);
        chk("g3_hit", {mistake, numMistake, indexCorrect}, {1'b0, 3'd3, 5'b10000});
      end
    end
    chk("g3_lose", {gameOver, win, guessReady}, 3'b100);
    do_guess(8'h50);
    chk("g3_frozen", {update, numMistake, correct}, {1'b0, 3'd6, 3'd1});

    // 6a: setWord during CHECK
    set_word("APPLE");
    guessValid = 1'b1; guess = 8'h50;
    tick();
    guessValid = 1'b0;
    setWord = 1'b1; word = "JAZZY";
    tick();
    setWord = 1'b0;
    chk("abort_state", {update, guessReady, letter, indexCorrect, correct}, {1'b0, 1'b1, 8'd0, 5'd0, 3'd0});
    tick();
    chk("abort_no_pulse", update, 0);
    do_guess(8'h5A);
    chk("jazzy_z", {indexCorrect, correct, letter}, {5'b00110, 3'd2, 8'h5A});
    do_guess(8'h42);
    chk("jazzy_b", {mistake, numMistake}, {1'b1, 3'd1});

    // 6b: asynchronous reset mid-game
    #2 nRst = 1'b0;
    #1 chk("async_rst", {guessReady, letter, indexCorrect, correct, numMistake, mistake, update, gameOver, win}, 0);
    tick();
    nRst = 1'b1;
    tick();
    chk("post_rst_idle", guessReady, 0);
    do_guess(8'h5A);
    chk("post_rst_ignored", update, 0);
    set_word("JAZZY");
    do_guess(8'h41);
    chk("reload_a", {indexCorrect, correct}, {5'b01000, 3'd1});
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
